caf_peak_select: RTL and testbench

//  Downstream of the CAF slice. Consumes one (out_max, index) result per frequency step over a

---
 rtl/caf_peak_select.sv | 145 ++++++++++++++
 tb/tb_caf_peak_select.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_select.sv
// caf_peak_select
// Collects one (out_max, index) slice result per frequency step of a sweep and
// reports the global peak of the sweep: magnitude, time lag and frequency bin.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           pulse: clear and arm a new sweep (restarts an open sweep)
//   m_axis_tvalid   upstream slice result valid
//   out_max, index  slice peak magnitude (unsigned) and its lag
//   s_axis_tready   ready to accept a slice result (high only while collecting)
//   peak_value      best magnitude of the sweep
//   peak_index      lag of the best magnitude
//   peak_freq       frequency bin (0..freq_bins-1) of the best magnitude
//   s_axis_tvalid   sweep result valid, held until m_axis_tready
//   m_axis_tready   downstream accepts the sweep result
//
// Optional feature, macro CAF_PEAK_THRESH_EN:
//   adds input threshold and output peak_detect = (peak_value >= threshold),
//   registered together with s_axis_tvalid. threshold is sampled on the
//   cycle the block enters DONE.
module caf_peak_select #(
    parameter int out_max_bits        = 5,
    parameter int length_counter_bits = 3,
    parameter int freq_bins           = 8,
    parameter int freq_counter_bits   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           m_axis_tvalid,
    input  logic [out_max_bits-1:0]        out_max,
    input  logic [length_counter_bits-1:0] index,
    output logic                           s_axis_tready,
    output logic [out_max_bits-1:0]        peak_value,
    output logic [length_counter_bits-1:0] peak_index,
    output logic [freq_counter_bits-1:0]   peak_freq,
    output logic                           s_axis_tvalid,
`ifdef CAF_PEAK_THRESH_EN
    input  logic [out_max_bits-1:0]        threshold,
    output logic                           peak_detect,
`endif
    input  logic                           m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [freq_counter_bits-1:0] LAST_BIN = freq_counter_bits'(freq_bins - 1);

    state_t                           state_r;
    logic [freq_counter_bits-1:0]     bin_r;
    logic [out_max_bits-1:0]          peak_value_r;
    logic [length_counter_bits-1:0]   peak_index_r;
    logic [freq_counter_bits-1:0]     peak_freq_r;
    logic                             tvalid_r;
    logic                             peak_detect_r;

    logic                             accept_s;
    logic                             load_s;
    logic                             last_s;
    logic [out_max_bits-1:0]          nxt_value_s;

    // Accept / compare decode; a start in COLLECT discards the concurrent sample.
    always_comb begin
        accept_s    = 1'b0;
        load_s      = 1'b0;
        last_s      = 1'b0;
        nxt_value_s = peak_value_r;
        accept_s    = (state_r == COLLECT) && m_axis_tvalid && !start;
        // Bin 0 always loads so a new sweep never compares against the old result.
        load_s      = accept_s && ((bin_r == '0) || (out_max > peak_value_r));
        last_s      = accept_s && (bin_r == LAST_BIN);
        nxt_value_s = load_s ? out_max : peak_value_r;
    end

    // Sweep FSM with bin counter, running peak and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            bin_r         <= '0;
            peak_value_r  <= '0;
            peak_index_r  <= '0;
            peak_freq_r   <= '0;
            tvalid_r      <= 1'b0;
            peak_detect_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= COLLECT;
                        bin_r   <= '0;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        bin_r <= '0;
                    end else if (accept_s) begin
                        if (load_s) begin
                            peak_value_r <= out_max;
                            peak_index_r <= index;
                            peak_freq_r  <= bin_r;
                        end
                        if (last_s) begin
                            state_r  <= DONE;
                            tvalid_r <= 1'b1;
`ifdef CAF_PEAK_THRESH_EN
                            peak_detect_r <= (nxt_value_s >= threshold);
`else
                            peak_detect_r <= 1'b0;
`endif
                        end else begin
                            bin_r <= bin_r + {{(freq_counter_bits-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE: begin
                    // start is ignored here: the result has to be drained first.
                    if (m_axis_tready) begin
                        state_r       <= IDLE;
                        tvalid_r      <= 1'b0;
                        peak_detect_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    tvalid_r      <= 1'b0;
                    peak_detect_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = (state_r == COLLECT);
    assign s_axis_tvalid = tvalid_r;
    assign peak_value    = peak_value_r;
    assign peak_index    = peak_index_r;
    assign peak_freq     = peak_freq_r;
`ifdef CAF_PEAK_THRESH_EN
    assign peak_detect   = peak_detect_r;
`endif

endmodule

// File: tb/tb_caf_peak_select.sv
module tb_caf_peak_select;

    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       m_tvalid = 1'b0;
    logic [4:0] out_max = 5'd0;
    logic [2:0] index = 3'd0;
    logic       s_axis_tready;
    logic [4:0] peak_value;
    logic [2:0] peak_index;
    logic [2:0] peak_freq;
    logic       s_axis_tvalid;
    logic       m_rdy = 1'b1;
`ifdef CAF_PEAK_THRESH_EN
    logic [4:0] threshold = 5'd9;
    logic       peak_detect;
`endif

    caf_peak_select dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .m_axis_tvalid (m_tvalid),
        .out_max       (out_max),
        .index         (index),
        .s_axis_tready (s_axis_tready),
        .peak_value    (peak_value),
        .peak_index    (peak_index),
        .peak_freq     (peak_freq),
        .s_axis_tvalid (s_axis_tvalid),
`ifdef CAF_PEAK_THRESH_EN
        .threshold     (threshold),
        .peak_detect   (peak_detect),
`endif
        .m_axis_tready (m_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int idx;
        int frq;
        int det;
        int acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   sv_q[$];
    int   si_q[$];
    int   vals[NB];
    int   idxs[NB];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen_first = 1'b0;
    exp_t last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the maximum magnitude of the sweep, attributed to the first bin reaching it.
    function automatic exp_t ref_peak();
        exp_t e;
        int m = 0;
        int k = 0;
        foreach (sv_q[i]) if (sv_q[i] > m) m = sv_q[i];
        for (int i = NB - 1; i >= 0; i--) if (sv_q[i] == m) k = i;
        e.val = m;
        e.idx = si_q[k];
        e.frq = k;
`ifdef CAF_PEAK_THRESH_EN
        e.det = (m >= int'(threshold)) ? 1 : 0;
`else
        e.det = 0;
`endif
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compares the presented result against the scoreboard front every cycle it is valid.
    always @(negedge clk) begin
        if (rst_n && s_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                chk("peak_value", int'(peak_value), exp_q[0].val);
                chk("peak_index", int'(peak_index), exp_q[0].idx);
                chk("peak_freq", int'(peak_freq), exp_q[0].frq);
`ifdef CAF_PEAK_THRESH_EN
                chk("peak_detect", int'(peak_detect), exp_q[0].det);
`endif
                chk("tready_in_done", int'(s_axis_tready), 0);
                if (!seen_first) begin
                    chk("valid_latency", cyc, exp_q[0].acc_cyc);
                    seen_first = 1'b1;
                end
                if (m_rdy) begin
                    last_exp = exp_q.pop_front();
                    seen_first = 1'b0;
                end
            end
        end
    end

    task automatic do_start(input bit with_sample);
        start = 1'b1;
        m_tvalid = with_sample;
        out_max = 5'd30;
        index = 3'd5;
        tick();
        start = 1'b0;
        m_tvalid = 1'b0;
        sv_q.delete();
        si_q.delete();
    endtask

    task automatic send_sample(input int v, input int i, input bit gaps);
        int n = 0;
        exp_t e;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                m_tvalid = 1'b0;
                out_max = 5'($urandom_range(0, 31));
                tick();
            end
        end
        m_tvalid = 1'b1;
        out_max = 5'(v);
        index = 3'(i);
        while (!s_axis_tready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("accept_timeout", 1, 0);
        tick();
        m_tvalid = 1'b0;
        sv_q.push_back(v);
        si_q.push_back(i);
        if (sv_q.size() == NB) begin
            e = ref_peak();
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            chk("tready_after_last", int'(s_axis_tready), 0);
        end
    endtask

    task automatic sweep(input bit gaps);
        for (int b = 0; b < NB; b++) send_sample(vals[b], idxs[b], gaps);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 1, 0);
            exp_q.delete();
        end
        chk("valid_drop", int'(s_axis_tvalid), 0);
        chk("idle_tready", int'(s_axis_tready), 0);
        chk("hold_value", int'(peak_value), last_exp.val);
        chk("hold_freq", int'(peak_freq), last_exp.frq);
    endtask

    task automatic load_fixed();
        int t[NB] = '{3, 7, 2, 9, 9, 1, 0, 4};
        for (int b = 0; b < NB; b++) begin
            vals[b] = t[b];
            idxs[b] = b;
        end
    endtask

    initial begin
        #2;
        chk("rst_tvalid", int'(s_axis_tvalid), 0);
        chk("rst_tready", int'(s_axis_tready), 0);
        chk("rst_value", int'(peak_value), 0);
        chk("rst_index", int'(peak_index), 0);
        chk("rst_freq", int'(peak_freq), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed sweep with a tie at bins 3 and 4.
        load_fixed();
        do_start(1'b0);
        sweep(1'b0);
        wait_drain();

`ifdef CAF_PEAK_THRESH_EN
        threshold = 5'd10;
        do_start(1'b0);
        sweep(1'b0);
        wait_drain();
        threshold = 5'd9;
`endif

        // Backpressure: result held 5 cycles while extra upstream data and a start are offered.
        m_rdy = 1'b0;
        do_start(1'b0);
        sweep(1'b1);
        m_tvalid = 1'b1;
        out_max = 5'd31;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_tvalid = 1'b0;
        m_rdy = 1'b1;
        wait_drain();

        // Abort: three large samples, restart with a concurrent sample, then eight samples of 2.
        do_start(1'b0);
        send_sample(31, 1, 1'b0);
        send_sample(31, 2, 1'b0);
        send_sample(30, 3, 1'b0);
        do_start(1'b1);
        for (int b = 0; b < NB; b++) begin
            vals[b] = 2;
            idxs[b] = 7 - b;
        end
        sweep(1'b0);
        wait_drain();

        // All-zero sweep with random valid gaps.
        for (int b = 0; b < NB; b++) begin
            vals[b] = 0;
            idxs[b] = $urandom_range(0, 7);
        end
        do_start(1'b0);
        sweep(1'b1);
        wait_drain();

        // Random sweeps; a narrow value range produces frequent ties.
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < NB; b++) begin
                vals[b] = (s < 4) ? $urandom_range(0, 7) : $urandom_range(0, 31);
                idxs[b] = $urandom_range(0, 7);
            end
            m_rdy = (s % 2 == 0);
            do_start(1'b0);
            sweep(s[0]);
            if (!m_rdy) begin
                repeat ($urandom_range(1, 4)) tick();
                m_rdy = 1'b1;
            end
            wait_drain();
        end

        // Reset mid-sweep after a non-zero result.
        load_fixed();
        do_start(1'b0);
        send_sample(25, 6, 1'b0);
        send_sample(3, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", int'(s_axis_tvalid), 0);
        chk("midrst_tready", int'(s_axis_tready), 0);
        chk("midrst_value", int'(peak_value), 0);
        chk("midrst_index", int'(peak_index), 0);
        chk("midrst_freq", int'(peak_freq), 0);
        sv_q.delete();
        si_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_tready", int'(s_axis_tready), 0);

        // Recovery sweep after reset.
        do_start(1'b0);
        sweep(1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
